prbs9_checker: RTL and testbench

//  Receive-end counterpart of prbs9_mod: self-synchronising PRBS9 (x^9+x^5+1) checker.

---
 rtl/prbs9_pkg.sv | 26 ++
 rtl/sat_counter.sv | 29 ++
 rtl/prbs9_checker.sv | 151 +++++++++++++++
 tb/tb_prbs9_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs9_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs9_pkg
// Description : PRBS9 (x^9+x^5+1) constants, checker FSM encoding, predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs9_pkg;

    localparam int c_lfsr_w = 9;
    localparam int c_tap_hi = 8;
    localparam int c_tap_lo = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // sr[k] holds the bit shifted in k+1 accepted bits ago
    function automatic logic prbs9_predict(input logic [c_lfsr_w-1:0] sr);
        return sr[c_tap_hi] ^ sr[c_tap_lo];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    // clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {W{1'b1}})) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs9_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs9_checker
// Description : Self-synchronising PRBS9 checker: seeds, verifies, locks, counts.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs9_checker
    import prbs9_pkg::*;
#(
    parameter int LOCK_CNT = 32,
    parameter int WIN_LEN  = 256,
    parameter int LOSS_THR = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_error,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [7:0]       o_loss_count
);

    localparam int c_seed_w = $clog2(c_lfsr_w + 1);
    localparam int c_ok_w   = $clog2(LOCK_CNT + 1);
    localparam int c_wbit_w = $clog2(WIN_LEN + 1);
    localparam int c_werr_w = $clog2(LOSS_THR + 1);

    state_t                r_state;
    logic [c_lfsr_w-1:0]   r_sr;
    logic [c_seed_w-1:0]   r_seed_cnt;
    logic [c_ok_w-1:0]     r_ok_cnt;
    logic [c_wbit_w-1:0]   r_win_bit;
    logic [c_werr_w-1:0]   r_win_err;
    logic                  r_locked;
    logic                  r_error;

    logic w_pred;
    logic w_mismatch;
    logic w_lock_acc;
    logic w_loss;

    assign w_pred     = prbs9_predict(r_sr);
    assign w_mismatch = i_bit ^ w_pred;
    assign w_lock_acc = i_enable && i_valid && (r_state == ST_LOCKED);
    assign w_loss     = w_lock_acc && w_mismatch && (r_win_err == c_werr_w'(LOSS_THR - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_sr       <= '0;
            r_seed_cnt <= '0;
            r_ok_cnt   <= '0;
            r_win_bit  <= '0;
            r_win_err  <= '0;
            r_locked   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (!i_enable) begin
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    // a bit arriving with the enable edge is the first seed bit
                    ST_IDLE: begin
                        r_state    <= ST_SEED;
                        r_seed_cnt <= '0;
                        if (i_valid) begin
                            r_sr       <= {r_sr[c_lfsr_w-2:0], i_bit};
                            r_seed_cnt <= c_seed_w'(1);
                        end
                    end
                    ST_SEED: if (i_valid) begin
                        r_sr <= {r_sr[c_lfsr_w-2:0], i_bit};
                        if (r_seed_cnt == c_seed_w'(c_lfsr_w - 1)) begin
                            r_state  <= ST_VERIFY;
                            r_ok_cnt <= '0;
                        end else begin
                            r_seed_cnt <= r_seed_cnt + c_seed_w'(1);
                        end
                    end
                    ST_VERIFY: if (i_valid) begin
                        r_sr <= {r_sr[c_lfsr_w-2:0], w_pred};
                        if (w_mismatch) begin
                            r_state    <= ST_SEED;
                            r_seed_cnt <= '0;
                        end else if (r_ok_cnt == c_ok_w'(LOCK_CNT - 1)) begin
                            r_state   <= ST_LOCKED;
                            r_locked  <= 1'b1;
                            r_win_bit <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_ok_cnt <= r_ok_cnt + c_ok_w'(1);
                        end
                    end
                    // the LFSR free-runs on its own prediction once locked
                    ST_LOCKED: if (i_valid) begin
                        r_sr    <= {r_sr[c_lfsr_w-2:0], w_pred};
                        r_error <= w_mismatch;
                        if (w_loss) begin
                            r_state    <= ST_SEED;
                            r_seed_cnt <= '0;
                            r_locked   <= 1'b0;
                        end else if (r_win_bit == c_wbit_w'(WIN_LEN - 1)) begin
                            r_win_bit <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_win_bit <= r_win_bit + c_wbit_w'(1);
                            r_win_err <= r_win_err + c_werr_w'(w_mismatch);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_locked = r_locked;
    assign o_error  = r_error;

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_clear),
        .i_inc   (w_lock_acc),
        .o_count (o_bit_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_clear),
        .i_inc   (w_lock_acc && w_mismatch),
        .o_count (o_err_count)
    );

    sat_counter #(.W(8)) u_loss_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_clear),
        .i_inc   (w_loss),
        .o_count (o_loss_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_prbs9_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs9_checker
// Description : Self-checking bench for prbs9_checker against a sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prbs9_checker;

    localparam int LOCK_CNT = 32;
    localparam int WIN_LEN  = 256;
    localparam int LOSS_THR = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, valid = 1'b0, bitin = 1'b0, clr = 1'b0;

    logic        locked, error;
    logic [31:0] bitc, errc;
    logic [7:0]  lossc;
    logic        s_locked, s_error;
    logic [7:0]  s_bitc, s_errc, s_lossc;

    always #5 clk = ~clk;

    prbs9_checker dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_valid(valid), .i_bit(bitin),
        .i_clear(clr), .o_locked(locked), .o_error(error),
        .o_bit_count(bitc), .o_err_count(errc), .o_loss_count(lossc)
    );

    prbs9_checker #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .i_enable(en), .i_valid(valid), .i_bit(bitin),
        .i_clear(clr), .o_locked(s_locked), .o_error(s_error),
        .o_bit_count(s_bitc), .o_err_count(s_errc), .o_loss_count(s_lossc)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint satv(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- reference model: sequence history, not a shift register
    int     m_state;   // 0 idle, 1 seeding, 2 verifying, 3 locked
    bit     m_ref[$];  // last 9 reference bits, [0] oldest
    int     m_seed, m_ok, m_wbit, m_werr;
    longint m_bits, m_errs, m_loss;
    bit     m_locked, m_error;

    function automatic void model_reset();
        m_state = 0; m_seed = 0; m_ok = 0; m_wbit = 0; m_werr = 0;
        m_bits = 0; m_errs = 0; m_loss = 0; m_locked = 0; m_error = 0;
        m_ref = {};
        for (int i = 0; i < 9; i++) m_ref.push_back(1'b0);
    endfunction

    function automatic void hist_push(input bit x);
        m_ref.push_back(x);
        void'(m_ref.pop_front());
    endfunction

    function automatic void model_step(input bit e, input bit v, input bit b, input bit c);
        bit p;
        bit inc_b, inc_e, inc_l;
        inc_b = 0; inc_e = 0; inc_l = 0;
        m_error = 0;
        if (!e) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_seed = 0;
            if (v) begin hist_push(b); m_seed = 1; end
        end else if (v) begin
            p = m_ref[0] ^ m_ref[4];   // x[n] = x[n-9] ^ x[n-5]
            if (m_state == 1) begin
                hist_push(b);
                m_seed++;
                if (m_seed == 9) begin m_state = 2; m_ok = 0; end
            end else if (m_state == 2) begin
                hist_push(p);
                if (b != p) begin
                    m_state = 1; m_seed = 0;
                end else begin
                    m_ok++;
                    if (m_ok == LOCK_CNT) begin m_state = 3; m_wbit = 0; m_werr = 0; end
                end
            end else begin
                hist_push(p);
                inc_b = 1;
                if (b != p) begin inc_e = 1; m_error = 1; m_werr++; end
                if (m_werr >= LOSS_THR) begin
                    m_state = 1; m_seed = 0; inc_l = 1;
                end else begin
                    m_wbit++;
                    if (m_wbit == WIN_LEN) begin m_wbit = 0; m_werr = 0; end
                end
            end
        end
        if (c) begin
            m_bits = 0; m_errs = 0; m_loss = 0;
        end else begin
            m_bits += inc_b; m_errs += inc_e; m_loss += inc_l;
        end
        m_locked = (m_state == 3);
    endfunction

    initial model_reset();

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step(en, valid, bitin, clr);
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("locked",      locked, m_locked);
            check("error",       error,  m_error);
            check("bit_count",   bitc,   satv(m_bits, 64'hFFFF_FFFF));
            check("err_count",   errc,   satv(m_errs, 64'hFFFF_FFFF));
            check("loss_count",  lossc,  satv(m_loss, 255));
            check("s_bit_count", s_bitc, satv(m_bits, 255));
            check("s_err_count", s_errc, satv(m_errs, 255));
        end
    end

    // ---------------- stimulus source
    bit src[9];

    function automatic bit src_next();
        bit x;
        x = src[0] ^ src[4];
        for (int i = 0; i < 8; i++) src[i] = src[i + 1];
        src[8] = x;
        return x;
    endfunction

    function automatic void src_seed();
        bit any;
        do begin
            any = 0;
            for (int i = 0; i < 9; i++) begin
                src[i] = 1'($urandom_range(0, 1));
                any |= src[i];
            end
        end while (!any);
    endfunction

    task automatic cyc(input bit e, input bit v, input bit b, input bit c);
        en = e; valid = v; bitin = b; clr = c;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input bit flip);
        cyc(1'b1, 1'b1, src_next() ^ flip, 1'b0);
    endtask

    task automatic relock_check(input string tag);
        for (int i = 0; i < 40; i++) send(1'b0);
        check({tag, "_not_yet"}, locked, 1'b0);
        send(1'b0);
        check({tag, "_at_41"}, locked, 1'b1);
    endtask

    int          n_lck;
    logic [10:0] seq;
    int          ones;
    int          burst;

    initial begin
        // pin the source recurrence with hand-derived values
        src = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 11; i++) seq = {seq[9:0], src_next()};
        check("prbs_first_11", seq, 11'b10000100011);
        ones = 0;
        for (int i = 0; i < 511; i++) ones += int'(src_next());
        check("prbs_period_ones", ones, 256);

        // reset state
        repeat (3) cyc(0, 0, 0, 0);
        rst = 1'b1;
        cmp_en = 1;
        cyc(0, 0, 0, 0);
        check("rst_locked", locked, 0);
        check("rst_bitc", bitc, 0);
        check("rst_lossc", lossc, 0);

        // lock at random phase, then a long clean run
        src_seed();
        relock_check("lock");
        n_lck = 0;
        repeat (10000) begin send(1'b0); n_lck++; end
        check("clean_bitc", bitc, 10000);
        check("clean_errc", errc, 0);

        // single inverted bit
        send(1'b1); n_lck++;
        check("single_err_pulse", error, 1);
        check("single_errc", errc, 1);
        check("single_locked", locked, 1);
        send(1'b0); n_lck++;
        check("single_pulse_end", error, 0);

        // align to a fresh window, then 16 inverted bits force loss
        while (n_lck % WIN_LEN != 0) begin send(1'b0); n_lck++; end
        repeat (15) send(1'b1);
        check("loss_15_locked", locked, 1);
        send(1'b1);
        check("loss_16_unlocked", locked, 0);
        check("loss_count", lossc, 1);
        check("loss_errc", errc, 17);
        relock_check("relock");

        // alternating valid
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 2000; i++) begin
            if (i % 2 == 0) send(1'b0);
            else cyc(1, 0, 1'($urandom_range(0, 1)), 0);
        end
        check("toggle_bitc", bitc, 1000);
        check("toggle_errc", errc, 0);

        // clear coincident with an error
        cyc(1, 1, src_next() ^ 1'b1, 1);
        check("clr_err_errc", errc, 0);
        check("clr_err_pulse", error, 1);

        // saturation on the narrow instance
        repeat (300) send(1'b0);
        check("sat_bitc8", s_bitc, 255);
        check("sat_bitc32", bitc, 300);
        repeat (10) send(1'b0);
        check("sat_hold", s_bitc, 255);

        // enable drop returns to idle
        cyc(0, 1, 0, 0);
        check("disable_locked", locked, 0);
        relock_check("reenable");

        // asynchronous reset mid-cycle
        #1 rst = 1'b0;
        #1;
        check("mid_rst_locked", locked, 0);
        check("mid_rst_bitc", bitc, 0);
        check("mid_rst_errc", errc, 0);
        check("mid_rst_lossc", lossc, 0);
        repeat (2) cyc(0, 0, 0, 0);
        rst = 1'b1;
        relock_check("post_rst");

        // randomized traffic checked every cycle by the model
        src_seed();
        burst = 0;
        for (int i = 0; i < 15000; i++) begin
            int r;
            bit v, f;
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            end else begin
                if (r < 8) burst = 24;
                if (r == 8) src_seed();
                v = ($urandom_range(0, 3) != 0);
                f = (burst > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 299) == 0);
                if (burst > 0) burst--;
                cyc(1, v, v ? (src_next() ^ f) : 1'($urandom_range(0, 1)), (r >= 990));
            end
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
